calc1_requester: RTL and testbench
==================================

CALC1_REQUESTER -- requirements
Module: calc1_requester

Interface
REQ-001 Parameter: TIMEOUT, default 100, max WAIT cycles before a transaction is abandoned (1..65535).
REQ-002 c_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; forces the reset state immediately, independent of c_clk.
REQ-004 host_valid  input  1  host transaction request.
REQ-005 host_ready  output  1  block can accept a transaction; high only in IDLE.
REQ-006 host_cmd  input  4  calc1 command code (0 no-op, 1 add, 2 sub, 5 shl, 6 shr; others passed through unchanged).
REQ-007 host_op1, host_op2  input  32 each  operand 1 and operand 2.
REQ-008 req_cmd_out  output  4  command to one calc1 request port (reqN_cmd_in).
REQ-009 req_data_out  output  32  data to the same port (reqN_data_in).
REQ-010 calc_resp  input  2  from calc1 out_respN (00 none, 01 ok, 10 overflow/invalid, 11 internal error).
REQ-011 calc_data  input  32  from calc1 out_dataN.
REQ-012 res_valid  output  1  result available; res_ready  input  1  host consumes the result.
REQ-013 res_resp  output  2; res_data  output  32; res_timeout  output  1  result fields.
REQ-014 spurious_cnt  output  8  saturating count of unexpected responses.

Function
REQ-015 FSM states: IDLE, SEND1, SEND2, WAIT, DONE; encoding is free.
REQ-016 IDLE: host_ready=1; host_valid=1 at an edge latches host_cmd/op1/op2, next state SEND1.
REQ-017 SEND1 (exactly 1 cycle): req_cmd_out=latched cmd, req_data_out=op1; next SEND2.
REQ-018 SEND2 (exactly 1 cycle): req_cmd_out=0, req_data_out=op2; next WAIT; wait counter cleared to 0.
REQ-019 WAIT: req_cmd_out=0, req_data_out=0; counter +1 per cycle.
REQ-020 WAIT, calc_resp!=00: capture calc_resp to res_resp and calc_data to res_data, res_timeout=0; next DONE.
REQ-021 WAIT, calc_resp==00 and counter reaches TIMEOUT: res_resp=00, res_data=0, res_timeout=1; next DONE.
REQ-022 Response and timeout in the same cycle: response wins, res_timeout=0.
REQ-023 DONE: res_valid=1, res_* stable; res_ready=1 at an edge -> IDLE; res_ready=0 holds DONE indefinitely.
REQ-024 req_cmd_out=0 and req_data_out=0 in IDLE and DONE.
REQ-025 req_cmd_out and req_data_out are register outputs; no combinational path from any input.
REQ-026 calc_resp!=00 sampled in IDLE, SEND1, SEND2 or DONE: spurious_cnt +1, saturating at 255; FSM unaffected.
REQ-027 Latency: accept at edge k -> SEND1 in cycle k+1, SEND2 in k+2; a response at edge m in WAIT gives res_valid from cycle m+1.
REQ-028 Back-to-back: at least one IDLE cycle between res_ready acceptance and the next SEND1.
REQ-029 host_valid outside IDLE is ignored; latched operands do not change until the next IDLE acceptance.

Reset
REQ-030 reset=1: state IDLE, req_cmd_out=0, req_data_out=0, res_valid=0, res_resp=0, res_data=0, res_timeout=0, spurious_cnt=0, counter=0; host_ready=1 once reset=0.
REQ-031 Reset mid-transaction (any state) abandons it; no result is produced and no partial command remains on req_* outputs.

Verification
REQ-032 Add: host_cmd=1, op1=1, op2=2; model returns resp 01 data 3 two cycles after SEND2 -> res_valid, res_resp=01, res_data=3, res_timeout=0; req_cmd_out sequence 1,0,0.
REQ-033 Timeout: TIMEOUT=4, calc_resp held 00 -> res_timeout=1, res_resp=00, res_data=0 after exactly 4 WAIT cycles.
REQ-034 Backpressure: res_ready=0 for 3 cycles in DONE -> res_* stable, host_ready=0, host_valid ignored; res_ready=1 -> IDLE.
REQ-035 Spurious: calc_resp=01 for 300 cycles in IDLE -> spurious_cnt=255, FSM stays IDLE.
REQ-036 Reset in WAIT: reset pulse -> all outputs at reset values immediately; no res_valid after the late calc_resp=01.
REQ-037 Overflow: host_cmd=1, op1=32'hFFFFFFFF, op2=1; model returns resp 10 -> res_resp=10 passed through, res_timeout=0.

Source files
------------

// File: rtl/calc1_requester_if.sv
// Bundle of host, calc1-port and result signals for calc1_requester.
// The slave modport is the requester block itself; the master modport is
// whatever drives it (host plus calc1 response side).
interface calc1_requester_if;

    // Host request channel
    logic        host_valid;
    logic        host_ready;
    logic [3:0]  host_cmd;
    logic [31:0] host_op1;
    logic [31:0] host_op2;

    // calc1 request port (reqN_cmd_in / reqN_data_in)
    logic [3:0]  req_cmd_out;
    logic [31:0] req_data_out;

    // calc1 response port (out_respN / out_dataN)
    logic [1:0]  calc_resp;
    logic [31:0] calc_data;

    // Result channel back to the host
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_resp;
    logic [31:0] res_data;
    logic        res_timeout;

    // Saturating count of responses that arrived outside WAIT
    logic [7:0]  spurious_cnt;

    modport slave (
        input  host_valid,
        input  host_cmd,
        input  host_op1,
        input  host_op2,
        input  calc_resp,
        input  calc_data,
        input  res_ready,
        output host_ready,
        output req_cmd_out,
        output req_data_out,
        output res_valid,
        output res_resp,
        output res_data,
        output res_timeout,
        output spurious_cnt
    );

    modport master (
        output host_valid,
        output host_cmd,
        output host_op1,
        output host_op2,
        output calc_resp,
        output calc_data,
        output res_ready,
        input  host_ready,
        input  req_cmd_out,
        input  req_data_out,
        input  res_valid,
        input  res_resp,
        input  res_data,
        input  res_timeout,
        input  spurious_cnt
    );

endinterface

// File: rtl/calc1_requester.sv
// calc1_requester: drives one calc1 request port with a two-beat command
// (cmd+op1, then op2), waits for the matching response or a timeout, and
// presents the outcome to the host on a result channel.
//
// Handshake rules (both channels):
//   - A transfer happens on a rising c_clk edge where valid and ready are
//     both high.
//   - Host request: host_ready is high only in IDLE; host_valid seen in any
//     other state is ignored and the operands already latched are kept.
//   - Result: once res_valid rises it stays high with res_resp/res_data/
//     res_timeout frozen until an edge with res_ready high.
//
// All outputs are registers; nothing on the req_* or res_* side has a
// combinational path from an input.
module calc1_requester #(
    parameter int TIMEOUT = 100  // WAIT cycles before giving up (1..65535)
) (
    input  logic               c_clk,
    input  logic               reset,
    calc1_requester_if.slave   bus,
    output logic [2:0]         state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEND1 = 3'd1,
        S_SEND2 = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Value of the wait counter in the last WAIT cycle allowed; the counter
    // starts at 0, so leaving when it equals TIMEOUT-1 gives exactly
    // TIMEOUT cycles spent in WAIT.
    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

    state_t      state;
    logic [31:0] op2_q;     // second beat, held until SEND1 puts it out
    logic [15:0] wait_cnt;  // cycles spent in WAIT so far
    logic [7:0]  spur_q;

    assign state_dbg        = state;
    assign bus.spurious_cnt = spur_q;

    // Main transaction FSM with all channel outputs registered alongside it.
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            state            <= S_IDLE;
            bus.host_ready   <= 1'b1;
            bus.req_cmd_out  <= 4'd0;
            bus.req_data_out <= 32'd0;
            op2_q            <= 32'd0;
            wait_cnt         <= 16'd0;
            bus.res_valid    <= 1'b0;
            bus.res_resp     <= 2'b00;
            bus.res_data     <= 32'd0;
            bus.res_timeout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Accept: the first beat is loaded straight into the
                    // output registers so it appears in the SEND1 cycle.
                    if (bus.host_valid) begin
                        bus.req_cmd_out  <= bus.host_cmd;
                        bus.req_data_out <= bus.host_op1;
                        op2_q            <= bus.host_op2;
                        bus.host_ready   <= 1'b0;
                        state            <= S_SEND1;
                    end
                end

                S_SEND1: begin
                    // Second beat carries no command, only operand 2.
                    bus.req_cmd_out  <= 4'd0;
                    bus.req_data_out <= op2_q;
                    state            <= S_SEND2;
                end

                S_SEND2: begin
                    bus.req_cmd_out  <= 4'd0;
                    bus.req_data_out <= 32'd0;
                    wait_cnt         <= 16'd0;
                    state            <= S_WAIT;
                end

                S_WAIT: begin
                    // A response in the final WAIT cycle still beats the
                    // timeout, so it is tested first.
                    if (bus.calc_resp != 2'b00) begin
                        bus.res_resp    <= bus.calc_resp;
                        bus.res_data    <= bus.calc_data;
                        bus.res_timeout <= 1'b0;
                        bus.res_valid   <= 1'b1;
                        state           <= S_DONE;
                    end else if (wait_cnt == LAST_WAIT) begin
                        bus.res_resp    <= 2'b00;
                        bus.res_data    <= 32'd0;
                        bus.res_timeout <= 1'b1;
                        bus.res_valid   <= 1'b1;
                        state           <= S_DONE;
                    end
                    wait_cnt <= wait_cnt + 16'd1;
                end

                S_DONE: begin
                    // Hold the result until the host takes it; the return
                    // to IDLE guarantees an idle cycle before the next send.
                    if (bus.res_ready) begin
                        bus.res_valid  <= 1'b0;
                        bus.host_ready <= 1'b1;
                        state          <= S_IDLE;
                    end
                end

                default: begin
                    bus.req_cmd_out  <= 4'd0;
                    bus.req_data_out <= 32'd0;
                    bus.res_valid    <= 1'b0;
                    bus.host_ready   <= 1'b1;
                    state            <= S_IDLE;
                end
            endcase
        end
    end

    // Count responses that show up when no transaction is waiting for one.
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            spur_q <= 8'd0;
        end else if (state != S_WAIT && bus.calc_resp != 2'b00 && spur_q != 8'hFF) begin
            spur_q <= spur_q + 8'd1;
        end
    end

endmodule

// File: tb/tb_calc1_requester.sv
// Directed bench for calc1_requester with TIMEOUT=4. The bench plays both the
// host and a hand-scripted calc1 response port.
module tb_calc1_requester;

    logic       c_clk;
    logic       reset;
    logic [2:0] state_dbg;

    int checks   = 0;
    int failures = 0;

    // Expected results: {timeout, resp, data}
    logic [34:0] exp_q[$];

    calc1_requester_if bus();

    calc1_requester #(.TIMEOUT(4)) dut (
        .c_clk     (c_clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock and watchdog
    initial begin
        c_clk = 1'b0;
        forever #5 c_clk = ~c_clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    // Comparison point
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle away from the edge
    task automatic step();
        @(posedge c_clk);
        #1;
    endtask

    // Issue one request from IDLE and follow it through SEND1/SEND2 into WAIT
    task automatic send(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
        check("host_ready_before_send", 32'(bus.host_ready), 32'd1);
        bus.host_valid = 1'b1;
        bus.host_cmd   = cmd;
        bus.host_op1   = a;
        bus.host_op2   = b;
        step();
        // Scribble on the host bus: latched operands must not follow it
        bus.host_valid = 1'b0;
        bus.host_cmd   = 4'hF;
        bus.host_op1   = 32'hDEAD_BEEF;
        bus.host_op2   = 32'hDEAD_BEEF;
        check("send1_state", 32'(state_dbg), 32'd1);
        check("send1_cmd", 32'(bus.req_cmd_out), 32'(cmd));
        check("send1_data", bus.req_data_out, a);
        check("send1_host_ready", 32'(bus.host_ready), 32'd0);
        step();
        check("send2_state", 32'(state_dbg), 32'd2);
        check("send2_cmd", 32'(bus.req_cmd_out), 32'd0);
        check("send2_data", bus.req_data_out, b);
        step();
        check("wait_state", 32'(state_dbg), 32'd3);
        check("wait_cmd", 32'(bus.req_cmd_out), 32'd0);
        check("wait_data", bus.req_data_out, 32'd0);
    endtask

    // calc1 response pulse lasting one cycle
    task automatic respond(input logic [1:0] resp, input logic [31:0] data);
        bus.calc_resp = resp;
        bus.calc_data = data;
        step();
        bus.calc_resp = 2'b00;
        bus.calc_data = 32'd0;
    endtask

    // Scoreboard: compare the presented result with the oldest expectation
    task automatic expect_result();
        logic [34:0] e;
        check("res_valid_done", 32'(bus.res_valid), 32'd1);
        check("done_state", 32'(state_dbg), 32'd4);
        if (exp_q.size() == 0) begin
            check("exp_q_nonempty", 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("res_timeout", 32'(bus.res_timeout), 32'(e[34]));
            check("res_resp", 32'(bus.res_resp), 32'(e[33:32]));
            check("res_data", bus.res_data, e[31:0]);
        end
    endtask

    // Host takes the result
    task automatic release_result();
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        check("release_state", 32'(state_dbg), 32'd0);
        check("release_res_valid", 32'(bus.res_valid), 32'd0);
        check("release_host_ready", 32'(bus.host_ready), 32'd1);
    endtask

    // Directed sequence
    initial begin
        reset          = 1'b1;
        bus.host_valid = 1'b0;
        bus.host_cmd   = 4'd0;
        bus.host_op1   = 32'd0;
        bus.host_op2   = 32'd0;
        bus.calc_resp  = 2'b00;
        bus.calc_data  = 32'd0;
        bus.res_ready  = 1'b0;

        // Reset state
        step();
        step();
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_req_cmd", 32'(bus.req_cmd_out), 32'd0);
        check("rst_req_data", bus.req_data_out, 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_resp", 32'(bus.res_resp), 32'd0);
        check("rst_res_data", bus.res_data, 32'd0);
        check("rst_res_timeout", 32'(bus.res_timeout), 32'd0);
        check("rst_spurious", 32'(bus.spurious_cnt), 32'd0);
        reset = 1'b0;
        step();
        check("post_rst_host_ready", 32'(bus.host_ready), 32'd1);
        check("post_rst_state", 32'(state_dbg), 32'd0);

        // Add 1+2: response ok/3 in the second WAIT cycle
        send(4'd1, 32'd1, 32'd2);
        step();
        check("add_still_waiting", 32'(bus.res_valid), 32'd0);
        exp_q.push_back({1'b0, 2'b01, 32'd3});
        respond(2'b01, 32'd3);
        expect_result();
        release_result();

        // Overflow: response code 10 passed through untouched
        send(4'd1, 32'hFFFF_FFFF, 32'd1);
        exp_q.push_back({1'b0, 2'b10, 32'd0});
        respond(2'b10, 32'd0);
        expect_result();
        release_result();

        // Timeout: no response, DONE after exactly 4 WAIT cycles
        send(4'd2, 32'd5, 32'd3);
        for (int i = 0; i < 3; i++) begin
            step();
            check("timeout_wait_state", 32'(state_dbg), 32'd3);
            check("timeout_wait_res_valid", 32'(bus.res_valid), 32'd0);
        end
        step();
        exp_q.push_back({1'b1, 2'b00, 32'd0});
        expect_result();
        release_result();

        // Response in the final WAIT cycle beats the timeout
        send(4'd5, 32'd1, 32'd4);
        step();
        step();
        step();
        check("late_resp_wait_state", 32'(state_dbg), 32'd3);
        exp_q.push_back({1'b0, 2'b01, 32'd16});
        respond(2'b01, 32'd16);
        expect_result();
        release_result();

        // Backpressure in DONE with host_valid pushing and a stray response
        send(4'd6, 32'd8, 32'd1);
        exp_q.push_back({1'b0, 2'b01, 32'd4});
        respond(2'b01, 32'd4);
        expect_result();
        bus.host_valid = 1'b1;
        bus.host_cmd   = 4'd1;
        bus.host_op1   = 32'd77;
        bus.host_op2   = 32'd78;
        bus.calc_resp  = 2'b10;
        bus.calc_data  = 32'h1234;
        for (int i = 0; i < 3; i++) begin
            step();
            bus.calc_resp = 2'b00;
            bus.calc_data = 32'd0;
            check("bp_state", 32'(state_dbg), 32'd4);
            check("bp_res_valid", 32'(bus.res_valid), 32'd1);
            check("bp_res_resp", 32'(bus.res_resp), 32'd1);
            check("bp_res_data", bus.res_data, 32'd4);
            check("bp_host_ready", 32'(bus.host_ready), 32'd0);
            check("bp_req_cmd", 32'(bus.req_cmd_out), 32'd0);
        end
        check("bp_spurious_in_done", 32'(bus.spurious_cnt), 32'd1);
        bus.host_valid = 1'b0;
        release_result();
        step();
        check("bp_no_queued_request", 32'(state_dbg), 32'd0);

        // Spurious responses in IDLE saturate at 255
        bus.calc_resp = 2'b01;
        repeat (10) step();
        check("spur_count_11", 32'(bus.spurious_cnt), 32'd11);
        check("spur_state_idle", 32'(state_dbg), 32'd0);
        repeat (290) step();
        bus.calc_resp = 2'b00;
        check("spur_saturated", 32'(bus.spurious_cnt), 32'd255);
        check("spur_state_idle_end", 32'(state_dbg), 32'd0);
        check("spur_res_valid", 32'(bus.res_valid), 32'd0);

        // Reset mid-WAIT: outputs clear at once, late response is spurious
        send(4'd1, 32'd2, 32'd3);
        step();
        reset = 1'b1;
        #1;
        check("arst_state", 32'(state_dbg), 32'd0);
        check("arst_req_cmd", 32'(bus.req_cmd_out), 32'd0);
        check("arst_req_data", bus.req_data_out, 32'd0);
        check("arst_res_valid", 32'(bus.res_valid), 32'd0);
        check("arst_res_timeout", 32'(bus.res_timeout), 32'd0);
        check("arst_spurious", 32'(bus.spurious_cnt), 32'd0);
        check("arst_host_ready", 32'(bus.host_ready), 32'd1);
        step();
        reset = 1'b0;
        respond(2'b01, 32'd5);
        check("arst_late_res_valid", 32'(bus.res_valid), 32'd0);
        repeat (3) step();
        check("arst_late_state", 32'(state_dbg), 32'd0);
        check("arst_late_res_valid2", 32'(bus.res_valid), 32'd0);
        check("arst_late_spurious", 32'(bus.spurious_cnt), 32'd1);

        // Recovery after reset: shl with a quick answer
        send(4'd5, 32'd1, 32'd2);
        exp_q.push_back({1'b0, 2'b01, 32'd4});
        respond(2'b01, 32'd4);
        expect_result();
        release_result();

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
